flu_down_converter: RTL and testbench

FLU_DOWN_CONVERTER -- requirements
Module: flu_down_converter

---
 rtl/flu_down_converter.sv | 139 +++++++++++++
 tb/tb_flu_down_converter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/flu_down_converter.sv
// FLU width down-converter: splits each RX word into TX_DATA_WIDTH segments and forwards only the segments carrying packet bytes.
// Combinational (zero-latency) data path; TX_DST_RDY low freezes the segment index and stalls RX until the last valid segment goes out.
module flu_down_converter #(
  parameter int RX_DATA_WIDTH    = 512,
  parameter int RX_SOP_POS_WIDTH = 3,
  parameter int TX_DATA_WIDTH    = 64,
  localparam int SOP_PW   = (RX_SOP_POS_WIDTH > 0) ? RX_SOP_POS_WIDTH : 1,
  localparam int RX_EOP_W = $clog2(RX_DATA_WIDTH / 8),
  localparam int TX_EOP_W = $clog2(TX_DATA_WIDTH / 8)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [RX_DATA_WIDTH-1:0] RX_DATA,
  input  logic [SOP_PW-1:0]        RX_SOP_POS,
  input  logic [RX_EOP_W-1:0]      RX_EOP_POS,
  input  logic                     RX_SOP,
  input  logic                     RX_EOP,
  input  logic                     RX_SRC_RDY,
  output logic                     RX_DST_RDY,
  output logic [TX_DATA_WIDTH-1:0] TX_DATA,
  output logic [TX_EOP_W-1:0]      TX_EOP_POS,
  output logic                     TX_SOP,
  output logic                     TX_EOP,
  output logic                     TX_SRC_RDY,
  input  logic                     TX_DST_RDY
);

  localparam int RATIO        = RX_DATA_WIDTH / TX_DATA_WIDTH;
  localparam int SEG_W        = $clog2(RATIO);
  localparam int SOP_BLK      = RX_DATA_WIDTH >> RX_SOP_POS_WIDTH;
  localparam int SEGS_PER_SOP = SOP_BLK / TX_DATA_WIDTH;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || SOP_BLK < TX_DATA_WIDTH ||
      (SOP_BLK % TX_DATA_WIDTH) != 0 || TX_DATA_WIDTH < 16 || (TX_DATA_WIDTH % 8) != 0) begin : g_param_check
    $error("flu_down_converter: illegal width parameters");
  end

  logic [SEG_W-1:0]         idx;
  logic                     inpkt;
  logic [SEG_W-1:0]         sop_seg;
  logic [SEG_W-1:0]         eop_seg;
  logic [SEG_W-1:0]         cur_seg;
  logic [RATIO-1:0]         seg_vld;
  logic                     cur_vld;
  logic                     cur_last;
  logic                     word_empty;
  logic                     ends_pkt;
  logic                     tx_xfer;
  logic                     word_done;
  logic                     inpkt_next;
  logic [TX_DATA_WIDTH-1:0] seg_dat [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_seg
    assign seg_dat[gi] = RX_DATA[gi*TX_DATA_WIDTH +: TX_DATA_WIDTH];
  end

  if (RX_SOP_POS_WIDTH == 0) begin : g_sop_fixed
    assign sop_seg = '0;
  end else begin : g_sop_pos
    assign sop_seg = SEG_W'(32'(RX_SOP_POS) * 32'(SEGS_PER_SOP));
  end

  // Upper EOP_POS bits select the segment, lower bits the byte inside it.
  assign eop_seg    = RX_EOP_POS[RX_EOP_W-1:TX_EOP_W];
  assign TX_EOP_POS = RX_EOP_POS[TX_EOP_W-1:0];

  always_comb begin
    seg_vld = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (inpkt) begin
        if (!RX_EOP) begin
          seg_vld[i] = 1'b1;
        end else begin
          seg_vld[i] = (SEG_W'(i) <= eop_seg) ||
                       (RX_SOP && (sop_seg > eop_seg) && (SEG_W'(i) >= sop_seg));
        end
      end else if (RX_SOP) begin
        if (RX_EOP && (eop_seg >= sop_seg)) begin
          seg_vld[i] = (SEG_W'(i) >= sop_seg) && (SEG_W'(i) <= eop_seg);
        end else begin
          seg_vld[i] = (SEG_W'(i) >= sop_seg);
        end
      end
    end
  end

  // Lowest valid segment at or above idx, and whether anything valid lies beyond it.
  always_comb begin
    cur_vld  = 1'b0;
    cur_seg  = '0;
    cur_last = 1'b1;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (seg_vld[i] && (SEG_W'(i) >= idx)) begin
        cur_vld = 1'b1;
        cur_seg = SEG_W'(i);
      end
    end
    for (int i = 0; i < RATIO; i++) begin
      if (seg_vld[i] && (SEG_W'(i) > cur_seg)) begin
        cur_last = 1'b0;
      end
    end
  end

  assign word_empty = ~|seg_vld;
  assign ends_pkt   = RX_EOP && (inpkt || (RX_SOP && (eop_seg >= sop_seg)));

  assign TX_SRC_RDY = !RESET && RX_SRC_RDY && cur_vld;
  assign TX_DATA    = seg_dat[cur_seg];
  assign TX_SOP     = cur_vld && RX_SOP && (cur_seg == sop_seg);
  assign TX_EOP     = cur_vld && ends_pkt && (cur_seg == eop_seg);

  assign tx_xfer    = TX_SRC_RDY && TX_DST_RDY;
  assign RX_DST_RDY = !RESET && ((cur_vld && cur_last && TX_DST_RDY) || (RX_SRC_RDY && word_empty));
  assign word_done  = (tx_xfer && cur_last) || (!RESET && RX_SRC_RDY && word_empty);

  // Packet state after the word: a SOP placed behind the EOP leaves a packet open.
  always_comb begin
    case ({RX_SOP, RX_EOP})
      2'b11:   inpkt_next = (sop_seg > eop_seg);
      2'b10:   inpkt_next = 1'b1;
      2'b01:   inpkt_next = 1'b0;
      default: inpkt_next = inpkt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx   <= '0;
      inpkt <= 1'b0;
    end else if (word_done) begin
      idx   <= '0;
      inpkt <= inpkt_next;
    end else if (tx_xfer) begin
      idx   <= cur_seg + SEG_W'(1);
    end
  end

endmodule

// File: tb/tb_flu_down_converter.sv
// Directed bench for flu_down_converter: expected TX segments are queued per RX word, a negedge monitor pops and compares.
module tb_flu_down_converter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [511:0] RX_DATA;
  logic [2:0]   RX_SOP_POS;
  logic [5:0]   RX_EOP_POS;
  logic         RX_SOP;
  logic         RX_EOP;
  logic         RX_SRC_RDY;
  logic         RX_DST_RDY;
  logic [63:0]  TX_DATA;
  logic [2:0]   TX_EOP_POS;
  logic         TX_SOP;
  logic         TX_EOP;
  logic         TX_SRC_RDY;
  logic         TX_DST_RDY;

  always #5 CLK = ~CLK;

  flu_down_converter #(
    .RX_DATA_WIDTH(512), .RX_SOP_POS_WIDTH(3), .TX_DATA_WIDTH(64)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
    .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_EOP_POS(TX_EOP_POS), .TX_SOP(TX_SOP), .TX_EOP(TX_EOP),
    .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
  );

  typedef struct packed {
    logic [63:0] dat;
    logic        sop;
    logic        eop;
    logic [2:0]  eop_pos;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   tx_count = 0;
  int   base;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] seg_word(int id, int s);
    return {32'(id), 32'h5EC0_0000 | 32'(s)};
  endfunction

  function automatic logic [511:0] mk_word(int id);
    logic [511:0] w;
    for (int i = 0; i < 8; i++) w[i*64 +: 64] = seg_word(id, i);
    return w;
  endfunction

  task automatic expect_seg(int id, int s, bit sop, bit eop, int eop_pos, bit last);
    exp_t e;
    e.dat     = seg_word(id, s);
    e.sop     = sop;
    e.eop     = eop;
    e.eop_pos = 3'(eop_pos);
    e.last    = last;
    exp_q.push_back(e);
  endtask

  task automatic present(int id, bit sop, bit eop, int sop_pos, int eop_pos);
    RX_DATA    = mk_word(id);
    RX_SOP     = sop;
    RX_EOP     = eop;
    RX_SOP_POS = 3'(sop_pos);
    RX_EOP_POS = 6'(eop_pos);
    RX_SRC_RDY = 1'b1;
  endtask

  task automatic send_word(int id, bit sop, bit eop, int sop_pos, int eop_pos);
    bit done = 0;
    present(id, sop, eop, sop_pos, eop_pos);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (RX_DST_RDY === 1'b1) done = 1;
    end
    @(posedge CLK);
    #1;
    RX_SRC_RDY = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout word=%0d actual=no RX_DST_RDY required=accept", id);
    end
  endtask

  task automatic wait_tx(int n);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (tx_count >= n) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL tx_count_timeout actual=%0d required=%0d", tx_count, n);
    end
  endtask

  // Monitor: a presented beat must match the queue head, both while stalled and on transfer.
  always @(negedge CLK) begin
    if (!RESET && TX_SRC_RDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx actual=%h required=no beat", TX_DATA);
      end else if (TX_DST_RDY) begin
        mon_e = exp_q.pop_front();
        check("tx_data", TX_DATA, mon_e.dat);
        check("tx_sop", 64'(TX_SOP), 64'(mon_e.sop));
        check("tx_eop", 64'(TX_EOP), 64'(mon_e.eop));
        if (mon_e.eop) check("tx_eop_pos", 64'(TX_EOP_POS), 64'(mon_e.eop_pos));
        check("rx_dst_rdy", 64'(RX_DST_RDY), 64'(mon_e.last));
        tx_count++;
      end else begin
        check("stall_data", TX_DATA, exp_q[0].dat);
        check("stall_sop", 64'(TX_SOP), 64'(exp_q[0].sop));
        check("stall_eop", 64'(TX_EOP), 64'(exp_q[0].eop));
        check("stall_rx_dst_rdy", 64'(RX_DST_RDY), 64'd0);
      end
    end
  end

  initial begin
    RESET      = 1'b1;
    TX_DST_RDY = 1'b1;
    present(99, 1, 1, 0, 63);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    check("reset_rx_dst_rdy", 64'(RX_DST_RDY), 64'd0);
    @(posedge CLK);
    #1;
    RESET      = 1'b0;
    RX_SRC_RDY = 1'b0;

    // Full 64 B packet in one word
    for (int s = 0; s < 8; s++) expect_seg(1, s, s == 0, s == 7, 7, s == 7);
    send_word(1, 1, 1, 0, 63);

    // Short packet in segments 5..6
    expect_seg(2, 5, 1, 0, 0, 0);
    expect_seg(2, 6, 0, 1, 7, 1);
    send_word(2, 1, 1, 5, 55);

    // Open a packet, then a word that ends it and starts the next
    for (int s = 0; s < 8; s++) expect_seg(3, s, s == 0, 0, 0, s == 7);
    send_word(3, 1, 0, 0, 0);
    expect_seg(4, 0, 0, 0, 0, 0);
    expect_seg(4, 1, 0, 0, 0, 0);
    expect_seg(4, 2, 0, 1, 3, 0);
    expect_seg(4, 6, 1, 0, 0, 0);
    expect_seg(4, 7, 0, 0, 0, 1);
    send_word(4, 1, 1, 6, 19);
    // Packet still open: an EOP-only word must pass all segments
    for (int s = 0; s < 8; s++) expect_seg(5, s, 0, s == 7, 7, s == 7);
    send_word(5, 0, 1, 0, 63);

    // Ten-cycle TX stall after the second segment
    base = tx_count;
    for (int s = 0; s < 8; s++) expect_seg(6, s, s == 0, s == 7, 7, s == 7);
    fork
      send_word(6, 1, 1, 0, 63);
      begin
        wait_tx(base + 2);
        TX_DST_RDY = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        TX_DST_RDY = 1'b1;
      end
    join
    check("stall_total", 64'(tx_count - base), 64'd8);

    // Reset after three segments, then a SOP-less word is dropped at once
    base = tx_count;
    for (int s = 0; s < 3; s++) expect_seg(7, s, s == 0, 0, 0, 0);
    present(7, 1, 1, 0, 63);
    wait_tx(base + 3);
    RESET = 1'b1;
    @(negedge CLK);
    check("midreset_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    check("midreset_rx_dst_rdy", 64'(RX_DST_RDY), 64'd0);
    check("midreset_queue", 64'(exp_q.size()), 64'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    present(8, 0, 1, 0, 63);
    @(negedge CLK);
    check("drop_tx_src_rdy", 64'(TX_SRC_RDY), 64'd0);
    check("drop_rx_dst_rdy", 64'(RX_DST_RDY), 64'd1);
    @(posedge CLK);
    #1;
    RX_SRC_RDY = 1'b0;

    // Mid-word packet segments 2..5, EOP on byte 0 of segment 5
    for (int s = 2; s < 6; s++) expect_seg(9, s, s == 2, s == 5, 0, s == 5);
    send_word(9, 1, 1, 2, 40);

    // SOP and EOP in the same segment
    expect_seg(10, 3, 1, 1, 0, 1);
    send_word(10, 1, 1, 3, 24);

    // Alternating TX backpressure
    for (int s = 0; s < 8; s++) expect_seg(11, s, s == 0, s == 7, 7, s == 7);
    fork
      send_word(11, 1, 1, 0, 63);
      begin
        repeat (20) begin
          @(posedge CLK);
          #1;
          TX_DST_RDY = ~TX_DST_RDY;
        end
        TX_DST_RDY = 1'b1;
      end
    join

    repeat (5) @(posedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
